// File: rtl/plane_bitmap_ctrl_if.sv
// Command/response bundle for plane_bitmap_ctrl; BITMAP_POPCOUNT_EN adds popcount and any-free outputs.
`ifndef MAX_HOST_NUMBER
`define MAX_HOST_NUMBER 4
`endif
`ifndef MAX_PLANE_NUMBER
`define MAX_PLANE_NUMBER 8
`endif

interface plane_bitmap_ctrl_if #(
    parameter int unsigned MAX_HOST_NUMBER  = `MAX_HOST_NUMBER,
    parameter int unsigned MAX_PLANE_NUMBER = `MAX_PLANE_NUMBER
);
    localparam int unsigned WIDTH          = MAX_HOST_NUMBER;
    localparam int unsigned ADDR_BIT_WIDTH = (MAX_PLANE_NUMBER > 1) ? $clog2(MAX_PLANE_NUMBER) : 1;
    localparam int unsigned HOST_BIT_WIDTH = (MAX_HOST_NUMBER > 1) ? $clog2(MAX_HOST_NUMBER) : 1;

    logic                      i_cmd_valid;
    logic                      o_cmd_ready;
    logic [2:0]                i_cmd_op;
    logic [ADDR_BIT_WIDTH-1:0] i_cmd_addr;
    logic [HOST_BIT_WIDTH-1:0] i_cmd_host;
    logic [WIDTH-1:0]          i_cmd_wdata;
    logic                      o_rsp_valid;
    logic [WIDTH-1:0]          o_rsp_rdata;
    logic                      o_rsp_err;
    logic                      o_busy;
`ifdef BITMAP_POPCOUNT_EN
    localparam int unsigned POPCNT_WIDTH = $clog2(WIDTH + 1);
    logic [POPCNT_WIDTH-1:0]   o_rsp_popcnt;
    logic                      o_any_free;
`endif

    modport master (
        output i_cmd_valid, output i_cmd_op, output i_cmd_addr, output i_cmd_host, output i_cmd_wdata,
        input  o_cmd_ready, input o_rsp_valid, input o_rsp_rdata, input o_rsp_err, input o_busy
`ifdef BITMAP_POPCOUNT_EN
        , input o_rsp_popcnt, input o_any_free
`endif
    );

    modport slave (
        input  i_cmd_valid, input i_cmd_op, input i_cmd_addr, input i_cmd_host, input i_cmd_wdata,
        output o_cmd_ready, output o_rsp_valid, output o_rsp_rdata, output o_rsp_err, output o_busy
`ifdef BITMAP_POPCOUNT_EN
        , output o_rsp_popcnt, output o_any_free
`endif
    );
endinterface

// File: rtl/plane_bitmap_ctrl.sv
// Host-ownership bitmap (planes x hosts) with RMW set/clear and a clear-all sweep.
// Optional BITMAP_POPCOUNT_EN adds o_rsp_popcnt and o_any_free.
`ifndef MAX_HOST_NUMBER
`define MAX_HOST_NUMBER 4
`endif
`ifndef MAX_PLANE_NUMBER
`define MAX_PLANE_NUMBER 8
`endif

module plane_bitmap_ctrl #(
    parameter int unsigned MAX_HOST_NUMBER  = `MAX_HOST_NUMBER,
    parameter int unsigned MAX_PLANE_NUMBER = `MAX_PLANE_NUMBER
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    plane_bitmap_ctrl_if.slave   bus
);
    localparam int unsigned WIDTH          = MAX_HOST_NUMBER;
    localparam int unsigned MAX_ADDR       = MAX_PLANE_NUMBER;
    localparam int unsigned ADDR_BIT_WIDTH = (MAX_ADDR > 1) ? $clog2(MAX_ADDR) : 1;
    localparam int unsigned HOST_BIT_WIDTH = (MAX_HOST_NUMBER > 1) ? $clog2(MAX_HOST_NUMBER) : 1;

    localparam logic [2:0] OP_READ  = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_SET   = 3'd2;
    localparam logic [2:0] OP_CLR   = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;

    typedef enum logic [1:0] {IDLE, RMW, SWEEP} state_e;

    state_e                    state_q;
    logic [ADDR_BIT_WIDTH-1:0] ptr_q;
    logic                      from_cmd_q;
    logic [ADDR_BIT_WIDTH-1:0] addr_q;
    logic [HOST_BIT_WIDTH-1:0] host_q;
    logic                      set_q;
    logic                      ready_q;
    logic                      busy_q;
    logic                      rsp_valid_q;
    logic [WIDTH-1:0]          rsp_rdata_q;
    logic                      rsp_err_q;
    logic [WIDTH-1:0]          mem_q [MAX_ADDR];

    logic                      addr_ok_d;
    logic                      host_ok_d;
    logic                      cmd_err_d;
    logic [WIDTH-1:0]          row_rd_d;
    logic [WIDTH-1:0]          mask_d;
    logic                      sweep_last_d;
    logic                      sweep_penult_d;

    // Widen by one bit so the range checks stay meaningful for power-of-2 sizes.
    always_comb begin
        addr_ok_d = ({1'b0, bus.i_cmd_addr} < (ADDR_BIT_WIDTH + 1)'(MAX_ADDR));
        host_ok_d = ({1'b0, bus.i_cmd_host} < (HOST_BIT_WIDTH + 1)'(MAX_HOST_NUMBER));
        cmd_err_d = (bus.i_cmd_op > OP_CLEAR)
                 || ((bus.i_cmd_op != OP_CLEAR) && !addr_ok_d)
                 || (((bus.i_cmd_op == OP_SET) || (bus.i_cmd_op == OP_CLR)) && !host_ok_d);
        row_rd_d  = addr_ok_d ? mem_q[bus.i_cmd_addr] : '0;
        mask_d    = WIDTH'(1) << host_q;
        sweep_last_d   = (ptr_q == ADDR_BIT_WIDTH'(MAX_ADDR - 1));
        sweep_penult_d = (({1'b0, ptr_q} + 1'b1) == (ADDR_BIT_WIDTH + 1)'(MAX_ADDR - 1));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= SWEEP;
            ptr_q       <= '0;
            from_cmd_q  <= 1'b0;
            addr_q      <= '0;
            host_q      <= '0;
            set_q       <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.i_cmd_valid) begin
                        if (cmd_err_d) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else if (bus.i_cmd_op == OP_READ) begin
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= row_rd_d;
                        end else if (bus.i_cmd_op == OP_WRITE) begin
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= row_rd_d;
                            mem_q[bus.i_cmd_addr] <= bus.i_cmd_wdata;
                        end else if ((bus.i_cmd_op == OP_SET) || (bus.i_cmd_op == OP_CLR)) begin
                            state_q <= RMW;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                            addr_q  <= bus.i_cmd_addr;
                            host_q  <= bus.i_cmd_host;
                            set_q   <= (bus.i_cmd_op == OP_SET);
                        end else begin
                            state_q     <= SWEEP;
                            ptr_q       <= '0;
                            from_cmd_q  <= 1'b1;
                            ready_q     <= 1'b0;
                            busy_q      <= 1'b1;
                            rsp_valid_q <= (MAX_ADDR == 1);
                        end
                    end
                end
                RMW: begin
                    mem_q[addr_q] <= set_q ? (mem_q[addr_q] | mask_d) : (mem_q[addr_q] & ~mask_d);
                    rsp_valid_q   <= 1'b1;
                    rsp_rdata_q   <= mem_q[addr_q];
                    state_q       <= IDLE;
                    ready_q       <= 1'b1;
                    busy_q        <= 1'b0;
                end
                SWEEP: begin
                    mem_q[ptr_q] <= '0;
                    if (sweep_last_d) begin
                        state_q    <= IDLE;
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        from_cmd_q <= 1'b0;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                        // Registered pulse lands in the final sweep cycle, one before ready returns.
                        if (sweep_penult_d && from_cmd_q) rsp_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_cmd_ready = ready_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_rdata = rsp_rdata_q;
    assign bus.o_rsp_err   = rsp_err_q;
    assign bus.o_busy      = busy_q;

`ifdef BITMAP_POPCOUNT_EN
    localparam int unsigned POPCNT_WIDTH = $clog2(WIDTH + 1);

    logic [POPCNT_WIDTH-1:0] popcnt_d;
    logic                    any_free_d;
    logic                    any_free_q;

    always_comb begin
        popcnt_d = '0;
        if (rsp_valid_q) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                popcnt_d = popcnt_d + POPCNT_WIDTH'(rsp_rdata_q[i]);
            end
        end
        any_free_d = 1'b0;
        for (int unsigned r = 0; r < MAX_ADDR; r++) begin
            if (mem_q[r] == '0) any_free_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) any_free_q <= 1'b0;
        else          any_free_q <= any_free_d;
    end

    assign bus.o_rsp_popcnt = popcnt_d;
    assign bus.o_any_free   = any_free_q;
`endif
endmodule

// File: tb/tb_plane_bitmap_ctrl.sv
// Randomized self-checking bench for plane_bitmap_ctrl against a row-array reference model.
module tb_plane_bitmap_ctrl;
    localparam int unsigned NH = 4;
    localparam int unsigned NP = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    plane_bitmap_ctrl_if #(.MAX_HOST_NUMBER(NH), .MAX_PLANE_NUMBER(NP)) bus ();
    plane_bitmap_ctrl #(.MAX_HOST_NUMBER(NH), .MAX_PLANE_NUMBER(NP)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    // Non-power-of-2 instance to exercise address and host range checks.
    plane_bitmap_ctrl_if #(.MAX_HOST_NUMBER(3), .MAX_PLANE_NUMBER(6)) bus2 ();
    plane_bitmap_ctrl #(.MAX_HOST_NUMBER(3), .MAX_PLANE_NUMBER(6)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus2));

    int unsigned total = 0;
    int unsigned bad = 0;
    logic [3:0] ref_mem [NP];

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input int unsigned op, input int unsigned a, input int unsigned h,
                         input logic [3:0] wd, output logic [3:0] erd, output bit eerr,
                         output int unsigned lat);
        erd = 4'h0; eerr = 1'b0; lat = 1;
        if (op > 4 || (op != 4 && a >= NP) || ((op == 2 || op == 3) && h >= NH)) begin
            eerr = 1'b1;
        end else begin
            case (op)
                0: erd = ref_mem[a];
                1: begin erd = ref_mem[a]; ref_mem[a] = wd; end
                2: begin erd = ref_mem[a]; ref_mem[a][h] = 1'b1; lat = 2; end
                3: begin erd = ref_mem[a]; ref_mem[a][h] = 1'b0; lat = 2; end
                default: begin
                    for (int r = 0; r < NP; r++) ref_mem[r] = 4'h0;
                    lat = NP;
                end
            endcase
        end
    endtask

    task automatic issue(input int unsigned op, input int unsigned a, input int unsigned h,
                         input logic [3:0] wd, input string tag);
        logic [3:0] erd;
        bit eerr;
        int unsigned lat;
        int unsigned n;
        model(op, a, h, wd, erd, eerr, lat);
        n = 0;
        while (!bus.o_cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
        check({tag, ".ready"}, bus.o_cmd_ready, 1);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_op    = 3'(op);
        bus.i_cmd_addr  = 3'(a);
        bus.i_cmd_host  = 2'(h);
        bus.i_cmd_wdata = wd;
        @(posedge clk); #1;
        bus.i_cmd_valid = 1'b0;
        n = 1;
        while (!bus.o_rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        check({tag, ".lat"}, n, lat);
        check({tag, ".rdata"}, bus.o_rsp_rdata, erd);
        check({tag, ".err"}, bus.o_rsp_err, eerr);
`ifdef BITMAP_POPCOUNT_EN
        check({tag, ".popcnt"}, bus.o_rsp_popcnt, $countones(erd));
`endif
    endtask

    task automatic issue2(input int unsigned op, input int unsigned a, input int unsigned h,
                          input logic [2:0] wd, input int unsigned lat, input logic [2:0] erd,
                          input bit eerr, input string tag);
        int unsigned n;
        n = 0;
        while (!bus2.o_cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
        bus2.i_cmd_valid = 1'b1;
        bus2.i_cmd_op    = 3'(op);
        bus2.i_cmd_addr  = 3'(a);
        bus2.i_cmd_host  = 2'(h);
        bus2.i_cmd_wdata = wd;
        @(posedge clk); #1;
        bus2.i_cmd_valid = 1'b0;
        n = 1;
        while (!bus2.o_rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        check({tag, ".lat"}, n, lat);
        check({tag, ".rdata"}, bus2.o_rsp_rdata, erd);
        check({tag, ".err"}, bus2.o_rsp_err, eerr);
    endtask

    task automatic idle_cycle(input string tag);
        bit free;
        @(posedge clk); #1;
        check({tag, ".no_rsp"}, bus.o_rsp_valid, 0);
`ifdef BITMAP_POPCOUNT_EN
        free = 1'b0;
        for (int r = 0; r < NP; r++) if (ref_mem[r] == 4'h0) free = 1'b1;
        check({tag, ".popcnt0"}, bus.o_rsp_popcnt, 0);
        check({tag, ".any_free"}, bus.o_any_free, free);
`else
        free = 1'b0;
`endif
    endtask

    task automatic count_sweep(input string tag);
        int unsigned n;
        int unsigned seen;
        n = 0; seen = 0;
        do begin
            @(posedge clk); #1;
            n++;
            seen += bus.o_rsp_valid;
        end while (!bus.o_cmd_ready && n < 20);
        check({tag, ".len"}, n, NP);
        check({tag, ".rsp"}, seen, 0);
        check({tag, ".busy"}, bus.o_busy, 0);
        for (int r = 0; r < NP; r++) ref_mem[r] = 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned seen;
        int unsigned r, op;
        bus.i_cmd_valid = 1'b0; bus.i_cmd_op = '0; bus.i_cmd_addr = '0;
        bus.i_cmd_host = '0; bus.i_cmd_wdata = '0;
        bus2.i_cmd_valid = 1'b0; bus2.i_cmd_op = '0; bus2.i_cmd_addr = '0;
        bus2.i_cmd_host = '0; bus2.i_cmd_wdata = '0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.ready", bus.o_cmd_ready, 0);
        check("rst.rsp_valid", bus.o_rsp_valid, 0);
        check("rst.rdata", bus.o_rsp_rdata, 0);
        check("rst.err", bus.o_rsp_err, 0);
        check("rst.busy", bus.o_busy, 1);
`ifdef BITMAP_POPCOUNT_EN
        check("rst.any_free", bus.o_any_free, 0);
`endif
        rst_n = 1'b1;
        count_sweep("boot");

        for (int a = 0; a < NP; a++) issue(0, a, 0, 4'h0, "rd_boot");

        issue(1, 3, 0, 4'hA, "wr3");
        issue(0, 3, 0, 4'h0, "raw3");
        issue(2, 3, 0, 4'h0, "set3h0");
        issue(3, 3, 3, 4'h0, "clr3h3");
        issue(0, 3, 0, 4'h0, "rd3");
        issue(2, 3, 1, 4'h0, "set_again");
        issue(3, 3, 2, 4'h0, "clr_again");
        for (int o = 5; o < 8; o++) issue(o, 3, 0, 4'h0, "badop");
        issue(0, 3, 0, 4'h0, "rd3_after_err");

        issue(1, 0, 0, 4'h5, "wr0");
        issue(1, 7, 0, 4'hC, "wr7");
        issue(4, 0, 0, 4'h0, "clear_all");
        check("clear_all.ready_low_on_rsp", bus.o_cmd_ready, 0);
        check("clear_all.busy", bus.o_busy, 1);
        for (int a = 0; a < NP; a++) issue(0, a, 0, 4'h0, "rd_cleared");

        issue(1, 5, 0, 4'h9, "wr5_pre_rst");
        bus.i_cmd_valid = 1'b1; bus.i_cmd_op = 3'd4;
        @(posedge clk); #1;
        bus.i_cmd_valid = 1'b0;
        seen = 0;
        repeat (3) begin @(posedge clk); #1; seen += bus.o_rsp_valid; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        seen += bus.o_rsp_valid;
        rst_n = 1'b1;
        check("mid_sweep.no_rsp", seen, 0);
        count_sweep("resweep");
        issue(0, 5, 0, 4'h0, "rd5_after_resweep");

        // Small instance: six rows, three hosts.
        issue2(1, 5, 0, 3'h5, 1, 3'h0, 1'b0, "d2.wr5");
        issue2(0, 6, 0, 3'h0, 1, 3'h0, 1'b1, "d2.rd6");
        issue2(0, 7, 0, 3'h0, 1, 3'h0, 1'b1, "d2.rd7");
        issue2(2, 5, 3, 3'h0, 1, 3'h0, 1'b1, "d2.set_h3");
        issue2(2, 5, 2, 3'h0, 2, 3'h5, 1'b0, "d2.set_h2_noop");
        issue2(3, 5, 1, 3'h0, 2, 3'h5, 1'b0, "d2.clr_h1_noop");
        issue2(0, 5, 0, 3'h0, 1, 3'h5, 1'b0, "d2.rd5");
        issue2(4, 6, 0, 3'h0, 6, 3'h0, 1'b0, "d2.clear_all");
        issue2(0, 5, 0, 3'h0, 1, 3'h0, 1'b0, "d2.rd5_cleared");

`ifdef BITMAP_POPCOUNT_EN
        issue(1, 0, 0, 4'hF, "pc.wr0");
        issue(0, 0, 0, 4'h0, "pc.rd0");
        for (int a = 0; a < NP; a++) issue(1, a, 0, 4'h8, "pc.fill");
        repeat (2) idle_cycle("pc.full");
        issue(3, 7, 3, 4'h0, "pc.clr_last");
        repeat (2) idle_cycle("pc.free");
`endif

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 31);
            if (r < 9)       op = 0;
            else if (r < 17) op = 1;
            else if (r < 22) op = 2;
            else if (r < 27) op = 3;
            else if (r < 28) op = 4;
            else             op = $urandom_range(5, 7);
            issue(op, $urandom_range(0, NP - 1), $urandom_range(0, NH - 1),
                  4'($urandom), "rand");
            repeat ($urandom_range(0, 2)) idle_cycle("rand.gap");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
